sd_spi_cmd_link: RTL and testbench
==================================

Name: sd_spi_cmd_link

Overview:
- SPI-mode SD-card emulator front end.
- Oversamples the host SD clock, chip-select (DAT3) and MOSI (CMD line) in the clk_50 domain.
- Frames 48-bit commands, checks CRC7, tracks a reduced card state machine, and shifts R1/R2/R3/R7 responses out on MISO (DAT0).
- Sits between the SD pins and the block-transfer logic; data-block transfer is out of scope.

Parameters:
- NCR_BYTES, 1, number of 0xFF filler bytes between the command end bit and the response (1..8).
- OCR_VOLT, 24'hFF8000, OCR bits 23:0 reported by CMD58.

Ports:
- clk_50  input  1  system clock; at least 4x the sd_clk frequency.
- reset_n  input  1  asynchronous active-low reset.
- sd_clk  input  1  host SPI clock (SCLK).
- sd_cmd_i  input  1  MOSI.
- sd_dat_i  input  4  bit3 = CS_n; other bits ignored.
- sd_dat_o  output  4  bit0 = MISO; bits 3:1 = 1.
- sd_dat_t  output  4  output enable per bit; bit0 = 1 while CS asserted, others 0.
- spi_sel  output  1  synchronized CS active (CS_n low).
- cmd_in  output  48  last complete command frame, bit47 = start bit.
- cmd_in_act  output  1  one-clk_50 pulse when a frame completes.
- cmd_in_crc_good  output  1  CRC7 result of the last frame.
- card_state  output  4  0 = idle, 4 = tran.
- spi_cnt  output  8  bits shifted in the current response phase (debug).

Behaviour:
- Single clock clk_50, reset asynchronous active-low.
- Reset values: all outputs 0 except sd_dat_o = 4'b1111; card_state = 0; internal crc_on = 0, app_cmd = 0.
- sd_clk, sd_cmd_i and sd_dat_i[3] each pass through a 2-flop synchronizer.
- Rise/fall edges are derived from the synchronized sd_clk (previous vs current sample).
- CS_n high:
  - receiver and transmitter cleared; any response in progress is aborted;
  - MISO = 1; sd_dat_t = 0; spi_sel = 0.
- Receiver (sclk rise, CS low, not responding):
  - While idle, a sampled 0 starts a frame; 48 bits are shifted MSB first.
  - On bit 48: cmd_in <= frame; cmd_in_act pulses for 1 clk_50.
  - cmd_in_crc_good = (CRC7 over bits 47:8, poly x^7+x^3+1, init 0) == bits 7:1, AND bit46 = 1, AND bit0 = 1.
- CRC enforcement:
  - CMD0 and CMD8 are always checked.
  - Other commands are checked only when crc_on = 1.
  - A failed check gives R1 = 0x08 | idle; no state change.
- Command handling (R1 bit0 = idle (card_state==0), bit2 = illegal, bit3 = CRC error):
  - CMD0: card_state <= 0, crc_on <= 0, app_cmd <= 0; R1 = 0x01.
  - CMD8: R7 = R1, 0x00, 0x00, {4'h0, arg[11:8]}, arg[7:0].
  - CMD58: R3 = R1 + OCR. OCR = {busy_n, ccs, 6'b0, OCR_VOLT}; busy_n = ccs = (card_state==4). Idle OCR = 0x00FF8000; ready OCR = 0xC0FF8000.
  - CMD13: R2 = R1, 0x00.
  - CMD55: R1; app_cmd <= 1.
  - CMD41 with app_cmd = 1: card_state <= 4; R1 = 0x00.
  - CMD59: crc_on <= arg[0] (only with the optional feature); R1.
  - Any other command: R1 | 0x04.
- app_cmd clears after any command other than CMD55.
- Transmitter:
  - After frame end, MISO holds 1 for NCR_BYTES*8 sclk cycles.
  - Then 1–5 response bytes are sent MSB first, with MISO updated on sclk falling edges; a 40-bit shift register is used.
  - MISO returns to 1 afterwards and the receiver re-arms.
  - spi_cnt counts bits sent, clearing at response end.
- Host bits arriving during filler/response are ignored.

Optional Feature:
- Macro SD_SPI_CMD59_CRC_EN.
- Defined: CMD59 sets crc_on = arg[0]; with crc_on = 1 every command's CRC is enforced.
- Undefined: CMD59 returns R1 without effect; crc_on stays 0; only CMD0/CMD8 are checked.

Test Plan:
- 10 bytes 0xFF with CS_n high -> MISO reads 0xFF every byte; no cmd_in_act; spi_sel = 0.
- CS low, send FF 40 00 00 00 00 95 then FF bytes -> cmd_in_act once, crc_good = 1; MISO gives FF then 0x01, then FF.
- CMD8: 48 00 00 01 AA 87 -> FF, 01 00 00 01 AA.
- CMD58: 7A 00 00 00 00 FD while idle -> 01 00 FF 80 00. After CMD55 (77 00 00 00 00 65) + ACMD41 (69 40 00 00 00 77) giving R1 0x00, CMD58 -> 00 C0 FF 80 00.
- CMD13: 4D 00 00 00 00 0D -> 01 00. CMD0 with CRC byte 0x94 -> R1 0x09, state unchanged. Unknown CMD2 -> 0x05.
- CS_n raised mid-response, then a new CMD0 -> response aborted, MISO = 1 immediately; the fresh CMD0 answers 0x01. reset_n pulsed mid-frame -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sd_spi_cmd_link_if.sv
// sd_spi_cmd_link_if: SD pin bundle between an SPI host (master) and the card emulator (slave)
// Signals: sd_clk host SCLK, sd_cmd_i MOSI, sd_dat_i[3] CS_n, sd_dat_o[0] MISO, sd_dat_t output enables
interface sd_spi_cmd_link_if;
  logic       sd_clk;
  logic       sd_cmd_i;
  logic [3:0] sd_dat_i;
  logic [3:0] sd_dat_o;
  logic [3:0] sd_dat_t;
  modport master(output sd_clk, sd_cmd_i, sd_dat_i, input sd_dat_o, sd_dat_t);
  modport slave(input sd_clk, sd_cmd_i, sd_dat_i, output sd_dat_o, sd_dat_t);
endinterface

// File: rtl/sd_spi_cmd_link.sv
// sd_spi_cmd_link: SPI-mode SD card front end framing 48-bit commands, checking CRC7 and answering R1/R2/R3/R7
// Ports: clk_50/reset_n system clock and async active-low reset; sd (slave) SD pins;
// spi_sel CS active; cmd_in/cmd_in_act/cmd_in_crc_good last frame; card_state 0 idle, 4 tran;
// spi_cnt response bits sent. Macro SD_SPI_CMD59_CRC_EN lets CMD59 switch CRC enforcement on.
module sd_spi_cmd_link #(
  parameter int          NCR_BYTES = 1,
  parameter logic [23:0] OCR_VOLT  = 24'hFF8000
) (
  input  logic              clk_50,
  input  logic              reset_n,
  sd_spi_cmd_link_if.slave  sd,
  output logic              spi_sel,
  output logic [47:0]       cmd_in,
  output logic              cmd_in_act,
  output logic              cmd_in_crc_good,
  output logic [3:0]        card_state,
  output logic [7:0]        spi_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_RX, S_NCR, S_RESP} state_t;
  localparam logic [6:0] NCR_LAST = 7'(NCR_BYTES * 8 - 1);
  state_t state, state_n;
  logic [1:0] sclk_s, mosi_s, csn_s;
  logic sclk_q, miso, crc_on, app_cmd;
  logic [6:0] cnt;
  logic [46:0] rx_sh;
  logic [39:0] tx_sh, resp_data;
  logic [5:0] tx_len, resp_len;
  logic rise, fall, cs, start, frame_done, ncr_done, resp_end;
  logic idle, ready, crc_good, crc_bad, acmd41, known;
  logic [47:0] frame;
  logic [5:0] cmd_idx;
  logic [7:0] r1;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = {c[5:0], 1'b0} ^ ((c[6] ^ d[i]) ? 7'h09 : 7'h00);
    return c;
  endfunction

  assign rise       = sclk_s[1] & ~sclk_q;
  assign fall       = ~sclk_s[1] & sclk_q;
  assign cs         = ~csn_s[1];
  assign spi_sel    = cs;
  assign frame      = {rx_sh, mosi_s[1]};
  assign cmd_idx    = frame[45:40];
  assign start      = state == S_IDLE && rise && !mosi_s[1];
  assign frame_done = state == S_RX && rise && cnt == 7'd47;
  assign ncr_done   = state == S_NCR && rise && cnt == NCR_LAST;
  assign resp_end   = state == S_RESP && fall && spi_cnt == {2'b00, tx_len};
  assign idle       = card_state == 4'd0;
  assign ready      = card_state == 4'd4;
  assign r1         = {7'b0, idle};
  assign crc_good   = crc7(frame[47:8]) == frame[7:1] && frame[46] && frame[0];
  assign crc_bad    = (cmd_idx == 6'd0 || cmd_idx == 6'd8 || crc_on) && !crc_good;
  assign acmd41     = cmd_idx == 6'd41 && app_cmd;
  assign known      = cmd_idx inside {6'd0, 6'd8, 6'd13, 6'd55, 6'd58, 6'd59} || acmd41;
  // MISO is forced high the moment CS is seen released, before the shifter is cleared
  assign sd.sd_dat_o = {3'b111, miso | ~cs};
  assign sd.sd_dat_t = {3'b000, cs};

  // Response is left-aligned in 40 bits; resp_len says how many of them go out
  always_comb begin
    resp_len  = 6'd8;
    resp_data = {crc_bad ? (r1 | 8'h08) : acmd41 ? 8'h00 : cmd_idx == 6'd0 ? 8'h01 : known ? r1 : (r1 | 8'h04), 32'hFFFF_FFFF};
    if (!crc_bad && cmd_idx == 6'd8) begin
      resp_data = {r1, 16'h0000, 4'h0, frame[19:8]};
      resp_len  = 6'd40;
    end
    if (!crc_bad && cmd_idx == 6'd58) begin
      resp_data = {r1, ready, ready, 6'b0, OCR_VOLT};
      resp_len  = 6'd40;
    end
    if (!crc_bad && cmd_idx == 6'd13) begin
      resp_data = {r1, 8'h00, 24'hFF_FFFF};
      resp_len  = 6'd16;
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    state_n = !cs ? S_IDLE : start ? S_RX : frame_done ? S_NCR : ncr_done ? S_RESP : resp_end ? S_IDLE : state;
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      sclk_s          <= '0;
      mosi_s          <= '0;
      csn_s           <= 2'b11;
      sclk_q          <= 1'b0;
      miso            <= 1'b1;
      cnt             <= '0;
      rx_sh           <= '0;
      tx_sh           <= '1;
      tx_len          <= '0;
      spi_cnt         <= '0;
      cmd_in          <= '0;
      cmd_in_act      <= 1'b0;
      cmd_in_crc_good <= 1'b0;
      card_state      <= '0;
      crc_on          <= 1'b0;
      app_cmd         <= 1'b0;
    end else begin
      sclk_s     <= {sclk_s[0], sd.sd_clk};
      sclk_q     <= sclk_s[1];
      mosi_s     <= {mosi_s[0], sd.sd_cmd_i};
      csn_s      <= {csn_s[0], sd.sd_dat_i[3]};
      cmd_in_act <= frame_done;
      if (!cs) begin
        cnt     <= '0;
        miso    <= 1'b1;
        spi_cnt <= '0;
      end else begin
        if (start) begin
          rx_sh <= '0;
          cnt   <= 7'd1;
        end
        if (state == S_RX && rise) begin
          rx_sh <= {rx_sh[45:0], mosi_s[1]};
          cnt   <= frame_done ? 7'd0 : cnt + 7'd1;
        end
        if (state == S_NCR && rise) cnt <= cnt + 7'd1;
        if (frame_done) begin
          cmd_in          <= frame;
          cmd_in_crc_good <= crc_good;
          tx_sh           <= resp_data;
          tx_len          <= resp_len;
          if (!crc_bad) begin
            app_cmd <= cmd_idx == 6'd55;
            if (cmd_idx == 6'd0) begin
              card_state <= 4'd0;
              crc_on     <= 1'b0;
            end
            if (acmd41) card_state <= 4'd4;
`ifdef SD_SPI_CMD59_CRC_EN
            if (cmd_idx == 6'd59) crc_on <= frame[8];
`else
            if (cmd_idx == 6'd59) crc_on <= 1'b0;
`endif
          end
        end
        if (state == S_RESP && fall) begin
          miso    <= resp_end | tx_sh[39];
          tx_sh   <= {tx_sh[38:0], 1'b1};
          spi_cnt <= resp_end ? 8'd0 : spi_cnt + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sd_spi_cmd_link.sv
// tb_sd_spi_cmd_link: randomized and directed bench for sd_spi_cmd_link against a spec-level model
module tb_sd_spi_cmd_link;
  localparam int NCR  = 1;
  localparam int HALF = 80;
  logic clk_50 = 1'b0;
  logic reset_n = 1'b0;
  logic spi_sel, cmd_in_act, cmd_in_crc_good;
  logic [47:0] cmd_in;
  logic [3:0] card_state;
  logic [7:0] spi_cnt;
  int checks = 0, errors = 0, act_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] mid_cnt;
  bit m_ready, m_app, m_crc_on, m_good;

  sd_spi_cmd_link_if sd();

  sd_spi_cmd_link #(.NCR_BYTES(NCR)) dut (
    .clk_50(clk_50),
    .reset_n(reset_n),
    .sd(sd),
    .spi_sel(spi_sel),
    .cmd_in(cmd_in),
    .cmd_in_act(cmd_in_act),
    .cmd_in_crc_good(cmd_in_crc_good),
    .card_state(card_state),
    .spi_cnt(spi_cnt)
  );

  always #10 clk_50 = ~clk_50;
  always @(negedge clk_50) if (cmd_in_act === 1'b1) act_cnt++;

  // CRC7 as polynomial long division of d*x^7 by x^7+x^3+1
  function automatic logic [6:0] ref_crc(input logic [39:0] d);
    logic [46:0] v;
    v = {d, 7'b0};
    for (int i = 46; i >= 7; i--) if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  function automatic logic [47:0] mk(input logic [5:0] c, input logic [31:0] a);
    logic [39:0] h;
    h = {2'b01, c, a};
    return {h, ref_crc(h), 1'b1};
  endfunction

  task automatic model_cmd(input logic [47:0] f);
    logic [5:0] c;
    logic [7:0] r1;
    logic [39:0] rv;
    int n;
    c = f[45:40];
    r1 = m_ready ? 8'h00 : 8'h01;
    m_good = ref_crc(f[47:8]) == f[7:1] && f[46] && f[0];
    n = 1;
    rv = {r1 | 8'h04, 32'h0};
    if ((c == 6'd0 || c == 6'd8 || m_crc_on) && !m_good) rv[39:32] = r1 | 8'h08;
    else begin
      if (c == 6'd0) begin rv[39:32] = 8'h01; m_ready = 0; m_crc_on = 0; end
      if (c == 6'd8) begin rv = {r1, 8'h00, 8'h00, 4'h0, f[19:16], f[15:8]}; n = 5; end
      if (c == 6'd58) begin rv = {r1, m_ready ? 32'hC0FF_8000 : 32'h00FF_8000}; n = 5; end
      if (c == 6'd13) begin rv = {r1, 8'h00, 24'h0}; n = 2; end
      if (c == 6'd55 || c == 6'd59) rv[39:32] = r1;
      if (c == 6'd41 && m_app) begin rv[39:32] = 8'h00; m_ready = 1; end
`ifdef SD_SPI_CMD59_CRC_EN
      if (c == 6'd59) m_crc_on = f[8];
`endif
      m_app = c == 6'd55;
    end
    exp_q.delete();
    repeat (NCR) exp_q.push_back(8'hFF);
    for (int i = 0; i < n; i++) exp_q.push_back(rv[39 - 8*i -: 8]);
    exp_q.push_back(8'hFF);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      sd.sd_cmd_i = tx[i];
      #(HALF);
      rx[i] = sd.sd_dat_o[0];
      sd.sd_clk = 1'b1;
      #(HALF);
      sd.sd_clk = 1'b0;
    end
  endtask

  task automatic xfer_cmd(input logic [47:0] f, input int nread);
    logic [7:0] b;
    rx_q.delete();
    @(negedge clk_50);
    for (int k = 5; k >= 0; k--) spi_byte(f[8*k +: 8], b);
    for (int k = 0; k < nread; k++) begin
      spi_byte(8'hFF, b);
      rx_q.push_back(b);
      if (k == NCR) mid_cnt = spi_cnt;
    end
    #200;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #55;
    checks++;
    if (sd.sd_dat_o !== 4'hF) begin errors++; $display("FAIL reset_dat_o got %h want f", sd.sd_dat_o); end
    checks++;
    if ({sd.sd_dat_t, spi_sel, cmd_in, cmd_in_act, cmd_in_crc_good, card_state, spi_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got t=%h sel=%b cmd=%h act=%b crc=%b st=%h cnt=%h want all 0", sd.sd_dat_t, spi_sel, cmd_in, cmd_in_act, cmd_in_crc_good, card_state, spi_cnt);
    end
    reset_n = 1'b1;
    #100;
  endtask

  task automatic test_cs_high;
    logic [7:0] b;
    sd.sd_dat_i = 4'b1111;
    @(negedge clk_50);
    for (int k = 0; k < 10; k++) begin
      spi_byte(8'($urandom), b);
      checks++;
      if (b !== 8'hFF) begin errors++; $display("FAIL cs_high_miso byte %0d got %h want ff", k, b); end
    end
    checks++;
    if (act_cnt !== 0) begin errors++; $display("FAIL cs_high_act got %0d want 0", act_cnt); end
    checks++;
    if (spi_sel !== 1'b0 || sd.sd_dat_t !== 4'h0) begin errors++; $display("FAIL cs_high_sel got %b/%h want 0/0", spi_sel, sd.sd_dat_t); end
  endtask

  task automatic test_directed;
    logic [47:0] fr[9];
    logic [39:0] ev[9];
    int el[9];
    logic [7:0] b, want;
    int a0;
    fr = '{48'h40_0000_0000_95, 48'h48_0000_01AA_87, 48'h7A_0000_0000_FD, 48'h4D_0000_0000_0D, 48'h40_0000_0000_94,
           48'h42_0000_0000_01, 48'h77_0000_0000_65, 48'h69_4000_0000_77, 48'h7A_0000_0000_FD};
    ev = '{40'h01_0000_0000, 40'h01_0000_01AA, 40'h01_00FF_8000, 40'h01_0000_0000, 40'h09_0000_0000,
           40'h05_0000_0000, 40'h01_0000_0000, 40'h00_0000_0000, 40'h00_C0FF_8000};
    el = '{1, 5, 5, 2, 1, 1, 1, 1, 5};
    sd.sd_dat_i = 4'b0111;
    #100;
    checks++;
    if (spi_sel !== 1'b1 || sd.sd_dat_t !== 4'b0001) begin errors++; $display("FAIL cs_low_sel got %b/%h want 1/1", spi_sel, sd.sd_dat_t); end
    @(negedge clk_50);
    spi_byte(8'hFF, b);
    checks++;
    if (b !== 8'hFF) begin errors++; $display("FAIL lead_ff got %h want ff", b); end
    for (int k = 0; k < 9; k++) begin
      model_cmd(fr[k]);
      a0 = act_cnt;
      xfer_cmd(fr[k], NCR + el[k] + 1);
      for (int j = 0; j < NCR + el[k] + 1; j++) begin
        want = (j < NCR || j >= NCR + el[k]) ? 8'hFF : ev[k][39 - 8*(j-NCR) -: 8];
        checks++;
        if (rx_q[j] !== want) begin errors++; $display("FAIL directed_resp cmd %0d byte %0d got %h want %h", k, j, rx_q[j], want); end
      end
      checks++;
      if (cmd_in !== fr[k]) begin errors++; $display("FAIL directed_cmd_in %0d got %h want %h", k, cmd_in, fr[k]); end
      checks++;
      if (cmd_in_crc_good !== (k != 4 && k != 5)) begin errors++; $display("FAIL directed_crc_good %0d got %b want %b", k, cmd_in_crc_good, (k != 4 && k != 5)); end
      checks++;
      if (act_cnt - a0 !== 1) begin errors++; $display("FAIL directed_act %0d got %0d want 1", k, act_cnt - a0); end
      checks++;
      if (card_state !== (k >= 7 ? 4'd4 : 4'd0)) begin errors++; $display("FAIL directed_state %0d got %0d want %0d", k, card_state, (k >= 7 ? 4 : 0)); end
      checks++;
      if (mid_cnt !== 8'd8 || spi_cnt !== 8'd0) begin errors++; $display("FAIL directed_spi_cnt %0d got %0d/%0d want 8/0", k, mid_cnt, spi_cnt); end
    end
  endtask

  task automatic test_abort;
    logic [7:0] b;
    model_cmd(48'h48_0000_01AA_87);
    @(negedge clk_50);
    for (int k = 5; k >= 0; k--) spi_byte(8'(48'h48_0000_01AA_87 >> (8*k)), b);
    for (int k = 0; k < NCR + 2; k++) begin
      spi_byte(8'hFF, b);
      checks++;
      if (b !== exp_q[k]) begin errors++; $display("FAIL abort_partial byte %0d got %h want %h", k, b, exp_q[k]); end
    end
    sd.sd_dat_i = 4'b1111;
    #100;
    checks++;
    if (sd.sd_dat_o[0] !== 1'b1 || spi_sel !== 1'b0 || sd.sd_dat_t !== 4'h0 || spi_cnt !== 8'd0) begin
      errors++;
      $display("FAIL abort_idle got miso=%b sel=%b t=%h cnt=%0d want 1/0/0/0", sd.sd_dat_o[0], spi_sel, sd.sd_dat_t, spi_cnt);
    end
    sd.sd_dat_i = 4'b0111;
    #100;
    model_cmd(48'h40_0000_0000_95);
    xfer_cmd(48'h40_0000_0000_95, exp_q.size());
    for (int j = 0; j < exp_q.size(); j++) begin
      checks++;
      if (rx_q[j] !== exp_q[j]) begin errors++; $display("FAIL abort_cmd0 byte %0d got %h want %h", j, rx_q[j], exp_q[j]); end
    end
    checks++;
    if (card_state !== 4'd0) begin errors++; $display("FAIL abort_state got %0d want 0", card_state); end
  endtask

  task automatic test_random;
    logic [5:0] cl[10];
    logic [47:0] f;
    int a0;
    cl = '{6'd0, 6'd8, 6'd58, 6'd13, 6'd55, 6'd41, 6'd59, 6'd2, 6'd17, 6'd24};
    for (int it = 0; it < 20; it++) begin
      f = mk(cl[$urandom_range(9)], $urandom);
      if ($urandom_range(3) == 0) f[7:1] = f[7:1] ^ 7'($urandom_range(127, 1));
      model_cmd(f);
      a0 = act_cnt;
      xfer_cmd(f, exp_q.size());
      for (int j = 0; j < exp_q.size(); j++) begin
        checks++;
        if (rx_q[j] !== exp_q[j]) begin errors++; $display("FAIL random_resp it %0d cmd %h byte %0d got %h want %h", it, f, j, rx_q[j], exp_q[j]); end
      end
      checks++;
      if (cmd_in !== f || cmd_in_crc_good !== m_good) begin errors++; $display("FAIL random_frame it %0d got %h/%b want %h/%b", it, cmd_in, cmd_in_crc_good, f, m_good); end
      checks++;
      if (act_cnt - a0 !== 1) begin errors++; $display("FAIL random_act it %0d got %0d want 1", it, act_cnt - a0); end
      checks++;
      if (card_state !== (m_ready ? 4'd4 : 4'd0) || mid_cnt !== 8'd8) begin
        errors++;
        $display("FAIL random_state it %0d got %0d/%0d want %0d/8", it, card_state, mid_cnt, (m_ready ? 4 : 0));
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    model_cmd(48'h77_0000_0000_65);
    xfer_cmd(48'h77_0000_0000_65, exp_q.size());
    model_cmd(48'h69_4000_0000_77);
    xfer_cmd(48'h69_4000_0000_77, exp_q.size());
    checks++;
    if (card_state !== 4'd4) begin errors++; $display("FAIL pre_reset_state got %0d want 4", card_state); end
    @(negedge clk_50);
    for (int k = 0; k < 3; k++) spi_byte(8'($urandom) & 8'h7F, b);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (sd.sd_dat_o !== 4'hF) begin errors++; $display("FAIL async_reset_dat_o got %h want f", sd.sd_dat_o); end
    checks++;
    if ({sd.sd_dat_t, spi_sel, cmd_in, cmd_in_act, cmd_in_crc_good, card_state, spi_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs got t=%h sel=%b cmd=%h st=%h cnt=%h want all 0", sd.sd_dat_t, spi_sel, cmd_in, card_state, spi_cnt);
    end
    sd.sd_dat_i = 4'b1111;
    #50;
    reset_n = 1'b1;
    m_ready = 0;
    m_app = 0;
    m_crc_on = 0;
    #100;
    sd.sd_dat_i = 4'b0111;
    #100;
    model_cmd(48'h40_0000_0000_95);
    xfer_cmd(48'h40_0000_0000_95, exp_q.size());
    for (int j = 0; j < exp_q.size(); j++) begin
      checks++;
      if (rx_q[j] !== exp_q[j]) begin errors++; $display("FAIL post_reset_cmd0 byte %0d got %h want %h", j, rx_q[j], exp_q[j]); end
    end
  endtask

  initial begin
    sd.sd_clk = 1'b0;
    sd.sd_cmd_i = 1'b1;
    sd.sd_dat_i = 4'b1111;
    test_reset();
    test_cs_high();
    test_directed();
    test_abort();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
